sobel_stream: RTL and testbench

Streaming 3x3 Sobel gradient engine for raster-order pixel video. It buffers two image lines internally, forms a sliding 3x3 window and emits signed Ix/Iy gradients. Each result also carries a gradient magnitude and a thresholded edge flag. It sits between the pixel source (camera/frame reader) and the downstream edge/feature logic, one result per interior pixel.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_line_buffer.sv | 38 +++
 rtl/sobel_stream.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_sobel_stream.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared widths and mode constants for the streaming 3x3 Sobel engine.
//   grad_bits(n) : width of the signed Ix/Iy gradients for an n-bit pixel
//   mag_bits(n)  : width of the unsigned gradient magnitude for an n-bit pixel
//   MAG_L1       : magnitude = |Ix| + |Iy|
//   MAG_LINF     : magnitude = max(|Ix|, |Iy|)
// -----------------------------------------------------------------------------
package sobel_pkg;

  localparam int MAG_L1   = 32'sd0;
  localparam int MAG_LINF = 32'sd1;

  // Each gradient is a difference of two 1-2-1 weighted sums, so it spans
  // +/-4(2^n-1), which needs n+3 bits signed.
  function automatic int grad_bits(input int n);
    return n + 32'sd3;
  endfunction

  // |Ix|+|Iy| is at most 8(2^n-1), which fits n+3 bits unsigned.
  function automatic int mag_bits(input int n);
    return n + 32'sd3;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
// One image line of pixel storage, addressed by column. The read port is
// combinational so the stored value for the current column is available in
// the same cycle the new value is written (read-before-write). Contents are
// never cleared; the consumer gates out anything not yet written this frame.
// Ports:
//   clk      in   clock
//   wr_en    in   write the addressed entry at the rising edge
//   addr     in   column address (0 .. p_depth-1)
//   wr_data  in   value to store
//   rd_data  out  value currently stored at addr (old value during a write)
// -----------------------------------------------------------------------------
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int p_num_bits = 8,
  parameter int p_depth    = 640
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(p_depth)-1:0] addr,
  input  logic [p_num_bits-1:0]      wr_data,
  output logic [p_num_bits-1:0]      rd_data
);

  logic [p_num_bits-1:0] mem_r [0:p_depth-1];

  assign rd_data = mem_r[addr];

  // Line storage write port; no reset so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// -----------------------------------------------------------------------------
// sobel_stream
// Streaming 3x3 Sobel gradient engine for raster-order pixels. Two line
// buffers supply the two rows above the incoming pixel; a 3x3 window slides
// one column per accepted pixel. Results are emitted two cycles after the
// pixel that completes an interior window, one per interior pixel.
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   in_valid   in   pixel accepted this cycle
//   in_sof     in   with in_valid: pixel is row 0, col 0 (restarts frame)
//   in_pixel   in   unsigned pixel
//   threshold  in   edge threshold, compared in the magnitude stage
//   out_valid  out  single-cycle result strobe
//   out_ix     out  signed horizontal gradient (left minus right)
//   out_iy     out  signed vertical gradient (bottom minus top)
//   out_mag    out  unsigned magnitude (L1 or Linf per p_mag_mode)
//   out_edge   out  out_mag >= threshold
//   out_eol    out  last result of a line (centre col = p_img_width-2)
// -----------------------------------------------------------------------------
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int p_num_bits   = 8,
  parameter int p_img_width  = 640,
  parameter int p_img_height = 480,
  parameter int p_mag_mode   = 0
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  input  logic                                  in_sof,
  input  logic [p_num_bits-1:0]                 in_pixel,
  input  logic [mag_bits(p_num_bits)-1:0]       threshold,
  output logic                                  out_valid,
  output logic signed [grad_bits(p_num_bits)-1:0] out_ix,
  output logic signed [grad_bits(p_num_bits)-1:0] out_iy,
  output logic [mag_bits(p_num_bits)-1:0]       out_mag,
  output logic                                  out_edge,
  output logic                                  out_eol
);

  localparam int GW  = grad_bits(p_num_bits);
  localparam int MW  = mag_bits(p_num_bits);
  localparam int CW  = $clog2(p_img_width);
  localparam int RW  = $clog2(p_img_height);
  localparam int WIN = 32'sd3;

  localparam logic [CW-1:0] COL_LAST = CW'(p_img_width - 32'sd1);
  localparam logic [CW-1:0] COL_TWO  = CW'(32'd2);
  localparam logic [CW-1:0] COL_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] COL_ZERO = CW'(32'd0);
  localparam logic [RW-1:0] ROW_LAST = RW'(p_img_height - 32'sd1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(32'd2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(32'd1);
  localparam logic [RW-1:0] ROW_ZERO = RW'(32'd0);

  // Pixels are unsigned: widen with zeros before any signed arithmetic.
  function automatic logic signed [GW-1:0] zext(input logic [p_num_bits-1:0] x);
    return $signed({{(GW - p_num_bits){1'b0}}, x});
  endfunction

  // ---------------------------------------------------------------------------
  // Position tracking. col_r/row_r hold the position the next accepted pixel
  // will take; a qualified sof overrides that with (0,0).
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [CW-1:0] cur_col_s;
  logic [RW-1:0] cur_row_s;
  logic [CW-1:0] nxt_col_s;
  logic [RW-1:0] nxt_row_s;
  logic          col_last_s;
  logic          win_done_s;

  // Resolve the current pixel position and the position after it.
  always_comb begin
    if (in_valid && in_sof) begin
      cur_col_s = COL_ZERO;
      cur_row_s = ROW_ZERO;
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end

    col_last_s = (cur_col_s == COL_LAST);

    if (col_last_s) begin
      nxt_col_s = COL_ZERO;
      if (cur_row_s == ROW_LAST) begin
        nxt_row_s = ROW_ZERO;
      end else begin
        nxt_row_s = cur_row_s + ROW_ONE;
      end
    end else begin
      nxt_col_s = cur_col_s + COL_ONE;
      nxt_row_s = cur_row_s;
    end

    // The window centred one row up and one column left is fully inside
    // the current frame and current line only from (2,2) onward, which also
    // keeps stale columns from the previous line out of the results.
    win_done_s = in_valid && (cur_row_s >= ROW_TWO) && (cur_col_s >= COL_TWO);
  end

  // Position counters advance only on accepted pixels.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_r <= COL_ZERO;
      row_r <= ROW_ZERO;
    end else if (in_valid) begin
      col_r <= nxt_col_s;
      row_r <= nxt_row_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: line1 holds the previous row, line0 the row before that.
  // line0 is fed from line1's read data so a row moves up one buffer as the
  // new row overwrites it.
  // ---------------------------------------------------------------------------
  logic [p_num_bits-1:0] line0_rd_s;
  logic [p_num_bits-1:0] line1_rd_s;

  sobel_line_buffer #(
    .p_num_bits (p_num_bits),
    .p_depth    (p_img_width)
  ) u_line1 (
    .clk     (clk),
    .wr_en   (in_valid),
    .addr    (cur_col_s),
    .wr_data (in_pixel),
    .rd_data (line1_rd_s)
  );

  sobel_line_buffer #(
    .p_num_bits (p_num_bits),
    .p_depth    (p_img_width)
  ) u_line0 (
    .clk     (clk),
    .wr_en   (in_valid),
    .addr    (cur_col_s),
    .wr_data (line1_rd_s),
    .rd_data (line0_rd_s)
  );

  // ---------------------------------------------------------------------------
  // 3x3 window, win[row][col] with row 0 at the top and col 0 at the left.
  // ---------------------------------------------------------------------------
  logic [p_num_bits-1:0] win_r     [0:WIN-1][0:WIN-1];
  logic [p_num_bits-1:0] win_nxt_s [0:WIN-1][0:WIN-1];

  // Window after shifting in the new right-hand column.
  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN - 1; j++) begin
        win_nxt_s[i][j] = win_r[i][j+1];
      end
    end
    win_nxt_s[0][WIN-1] = line0_rd_s;
    win_nxt_s[1][WIN-1] = line1_rd_s;
    win_nxt_s[2][WIN-1] = in_pixel;
  end

  // Window registers shift on accepted pixels only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN; j++) begin
          win_r[i][j] <= '0;
        end
      end
    end else if (in_valid) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN; j++) begin
          win_r[i][j] <= win_nxt_s[i][j];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: gradients of the post-shift window, registered alongside the
  // window so the result lands two edges after its completing pixel.
  // ---------------------------------------------------------------------------
  logic signed [GW-1:0] left_s;
  logic signed [GW-1:0] right_s;
  logic signed [GW-1:0] top_s;
  logic signed [GW-1:0] bot_s;
  logic signed [GW-1:0] ix_s;
  logic signed [GW-1:0] iy_s;

  // 1-2-1 weighted column/row sums and their differences.
  always_comb begin
    left_s  = zext(win_nxt_s[0][0]) + (zext(win_nxt_s[1][0]) <<< 1'b1) + zext(win_nxt_s[2][0]);
    right_s = zext(win_nxt_s[0][2]) + (zext(win_nxt_s[1][2]) <<< 1'b1) + zext(win_nxt_s[2][2]);
    top_s   = zext(win_nxt_s[0][0]) + (zext(win_nxt_s[0][1]) <<< 1'b1) + zext(win_nxt_s[0][2]);
    bot_s   = zext(win_nxt_s[2][0]) + (zext(win_nxt_s[2][1]) <<< 1'b1) + zext(win_nxt_s[2][2]);
    ix_s    = left_s - right_s;
    iy_s    = bot_s - top_s;
  end

  logic                 s1_valid_r;
  logic                 s1_eol_r;
  logic signed [GW-1:0] s1_ix_r;
  logic signed [GW-1:0] s1_iy_r;

  // Stage-1 pipeline register; valid shifts every cycle, data only on valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_eol_r   <= 1'b0;
      s1_ix_r    <= '0;
      s1_iy_r    <= '0;
    end else begin
      s1_valid_r <= win_done_s;
      if (win_done_s) begin
        s1_eol_r <= col_last_s;
        s1_ix_r  <= ix_s;
        s1_iy_r  <= iy_s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: absolute values, magnitude and threshold compare.
  // ---------------------------------------------------------------------------
  logic [MW-1:0] abs_ix_s;
  logic [MW-1:0] abs_iy_s;
  logic [MW-1:0] sum_s;
  logic [MW-1:0] max_s;
  logic [MW-1:0] mag_s;
  logic          edge_s;

  // Magnitude selection; the L1 sum cannot overflow MW bits.
  always_comb begin
    if (s1_ix_r[GW-1]) begin
      abs_ix_s = MW'($unsigned(-s1_ix_r));
    end else begin
      abs_ix_s = MW'($unsigned(s1_ix_r));
    end

    if (s1_iy_r[GW-1]) begin
      abs_iy_s = MW'($unsigned(-s1_iy_r));
    end else begin
      abs_iy_s = MW'($unsigned(s1_iy_r));
    end

    sum_s = abs_ix_s + abs_iy_s;

    if (abs_ix_s >= abs_iy_s) begin
      max_s = abs_ix_s;
    end else begin
      max_s = abs_iy_s;
    end

    if (p_mag_mode == MAG_LINF) begin
      mag_s = max_s;
    end else begin
      mag_s = sum_s;
    end

    edge_s = (mag_s >= threshold);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_ix    <= '0;
      out_iy    <= '0;
      out_mag   <= '0;
      out_edge  <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_ix   <= s1_ix_r;
        out_iy   <= s1_iy_r;
        out_mag  <= mag_s;
        out_edge <= edge_s;
        out_eol  <= s1_eol_r;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// -----------------------------------------------------------------------------
// tb_sobel_stream
// Self-checking bench for sobel_stream with an 8x6 image of 8-bit pixels.
// Two instances share the stimulus: one with L1 magnitude, one with Linf.
// The reference model computes each interior result straight from the image
// array with the Sobel sums, and the expected output cycle from the cycle the
// completing pixel was accepted.
// -----------------------------------------------------------------------------
module tb_sobel_stream;

  localparam int N = 8;
  localparam int W = 8;
  localparam int H = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_sof;
  logic [N-1:0]      in_pixel;
  logic [N+2:0]      threshold;

  logic              out_valid;
  logic signed [N+2:0] out_ix;
  logic signed [N+2:0] out_iy;
  logic [N+2:0]      out_mag;
  logic              out_edge;
  logic              out_eol;

  logic              inf_valid;
  logic signed [N+2:0] inf_ix;
  logic signed [N+2:0] inf_iy;
  logic [N+2:0]      inf_mag;
  logic              inf_edge;
  logic              inf_eol;

  always #5 clk = ~clk;

  sobel_stream #(
    .p_num_bits   (N),
    .p_img_width  (W),
    .p_img_height (H),
    .p_mag_mode   (sobel_pkg::MAG_L1)
  ) dut (
    .clk (clk), .reset_n (reset_n), .in_valid (in_valid), .in_sof (in_sof),
    .in_pixel (in_pixel), .threshold (threshold),
    .out_valid (out_valid), .out_ix (out_ix), .out_iy (out_iy),
    .out_mag (out_mag), .out_edge (out_edge), .out_eol (out_eol)
  );

  sobel_stream #(
    .p_num_bits   (N),
    .p_img_width  (W),
    .p_img_height (H),
    .p_mag_mode   (sobel_pkg::MAG_LINF)
  ) dut_inf (
    .clk (clk), .reset_n (reset_n), .in_valid (in_valid), .in_sof (in_sof),
    .in_pixel (in_pixel), .threshold (threshold),
    .out_valid (inf_valid), .out_ix (inf_ix), .out_iy (inf_iy),
    .out_mag (inf_mag), .out_edge (inf_edge), .out_eol (inf_eol)
  );

  typedef struct packed {
    logic signed [15:0] ix;
    logic signed [15:0] iy;
    logic [15:0]        mag;
    logic               edg;
    logic               eol;
    logic [31:0]        stamp;
  } res_t;

  int          cyc = 0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;
  int          thr_i;
  int          img [0:H-1][0:W-1];
  res_t        got_q[$];
  res_t        exp_q[$];
  logic [15:0] got_inf_q[$];
  logic [15:0] exp_inf_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    res_t r;
    if (out_valid === 1'b1) begin
      r.ix    = out_ix;
      r.iy    = out_iy;
      r.mag   = 16'(out_mag);
      r.edg   = out_edge;
      r.eol   = out_eol;
      r.stamp = 32'(cyc);
      got_q.push_back(r);
    end
    if (inf_valid === 1'b1) got_inf_q.push_back(16'(inf_mag));
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference result for the window centred at (cr,cc) of img.
  task automatic push_expected(input int cr, input int cc, input int stamp);
    int left, right, top, bot, ix, iy, ax, ay;
    res_t e;
    left  = img[cr-1][cc-1] + 2*img[cr][cc-1] + img[cr+1][cc-1];
    right = img[cr-1][cc+1] + 2*img[cr][cc+1] + img[cr+1][cc+1];
    top   = img[cr-1][cc-1] + 2*img[cr-1][cc] + img[cr-1][cc+1];
    bot   = img[cr+1][cc-1] + 2*img[cr+1][cc] + img[cr+1][cc+1];
    ix = left - right;
    iy = bot - top;
    ax = (ix < 0) ? -ix : ix;
    ay = (iy < 0) ? -iy : iy;
    e.ix    = 16'(ix);
    e.iy    = 16'(iy);
    e.mag   = 16'(ax + ay);
    e.edg   = ((ax + ay) >= thr_i);
    e.eol   = (cc == W - 2);
    e.stamp = 32'(stamp);
    exp_q.push_back(e);
    exp_inf_q.push_back(16'((ax > ay) ? ax : ay));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_sof   = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Send img[r][c], optionally preceded by random bubbles that carry a
  // stray in_sof (must be ignored without in_valid).
  task automatic send_pixel(input int r, input int c, input bit sof, input int bubble_pct);
    for (int b = 0; b < 4 && ($urandom_range(99) < bubble_pct); b++) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(1));
      in_pixel = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = 8'(img[r][c]);
    @(posedge clk); #1;
    if (r >= 2 && c >= 2) push_expected(r - 1, c - 1, cyc + 1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int npix, input int bubble_pct);
    for (int p = 0; p < npix; p++) send_pixel(p / W, p % W, (p == 0), bubble_pct);
  endtask

  task automatic clear_queues();
    got_q.delete(); exp_q.delete(); got_inf_q.delete(); exp_inf_q.delete();
  endtask

  task automatic set_threshold(input int t);
    thr_i = t;
    threshold = 11'(t);
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255));
  endtask

  task automatic report_res(input string name, input int i);
    $display("FAIL %s[%0d]: got ix=%0d iy=%0d mag=%0d edge=%0b eol=%0b t=%0d, expected ix=%0d iy=%0d mag=%0d edge=%0b eol=%0b t=%0d",
             name, i, got_q[i].ix, got_q[i].iy, got_q[i].mag, got_q[i].edg, got_q[i].eol, got_q[i].stamp,
             exp_q[i].ix, exp_q[i].iy, exp_q[i].mag, exp_q[i].edg, exp_q[i].eol, exp_q[i].stamp);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    set_threshold(0);
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({out_valid, out_ix, out_iy, out_mag, out_edge, out_eol} !== 36'd0)
      $display("FAIL reset_outputs: got valid=%b ix=%0d iy=%0d mag=%0d edge=%b eol=%b, expected all 0",
               out_valid, out_ix, out_iy, out_mag, out_edge, out_eol);
    else pass_cnt++;
    chk_cnt++;
    if ({inf_valid, inf_mag} !== 12'd0)
      $display("FAIL reset_inf_outputs: got valid=%b mag=%0d, expected 0", inf_valid, inf_mag);
    else pass_cnt++;
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_constant();
    clear_queues();
    set_threshold(1);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
    send_frame(W * H, 0);
    idle(6);
    chk_cnt++;
    if (got_q.size() != 24) $display("FAIL const_count: got %0d results, expected 24", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[i] !== exp_q[i]) report_res("const_res", i);
      else pass_cnt++;
      chk_cnt++;
      if (got_q[i].eol !== ((i % 6) == 5))
        $display("FAIL const_eol[%0d]: got %b, expected %b", i, got_q[i].eol, ((i % 6) == 5));
      else pass_cnt++;
    end
  endtask

  task automatic test_vertical_step();
    clear_queues();
    set_threshold(500);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? 255 : 0;
    send_frame(W * H, 0);
    idle(6);
    chk_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL vstep_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[i] !== exp_q[i]) report_res("vstep_res", i);
      else pass_cnt++;
    end
    if (got_q.size() > 3) begin
      chk_cnt++;
      if (got_q[2].ix !== -16'sd1020 || got_q[2].mag !== 16'd1020 || got_q[2].edg !== 1'b1)
        $display("FAIL vstep_col3: got ix=%0d mag=%0d edge=%b, expected ix=-1020 mag=1020 edge=1",
                 got_q[2].ix, got_q[2].mag, got_q[2].edg);
      else pass_cnt++;
      chk_cnt++;
      if (got_q[3].ix !== -16'sd1020 || got_q[1].edg !== 1'b0)
        $display("FAIL vstep_col4: got ix=%0d col2 edge=%b, expected ix=-1020 col2 edge=0",
                 got_q[3].ix, got_q[1].edg);
      else pass_cnt++;
    end
  endtask

  task automatic test_horizontal_step();
    clear_queues();
    set_threshold(400);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r >= 3) ? 200 : 0;
    send_frame(W * H, 0);
    idle(6);
    chk_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL hstep_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[i] !== exp_q[i]) report_res("hstep_res", i);
      else pass_cnt++;
    end
    chk_cnt++;
    if (got_inf_q.size() != exp_inf_q.size()) $display("FAIL hstep_inf_count: got %0d, expected %0d", got_inf_q.size(), exp_inf_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_inf_q.size() && i < exp_inf_q.size(); i++) begin
      chk_cnt++;
      if (got_inf_q[i] !== exp_inf_q[i]) $display("FAIL hstep_inf_mag[%0d]: got %0d, expected %0d", i, got_inf_q[i], exp_inf_q[i]);
      else pass_cnt++;
    end
    if (got_inf_q.size() > 6) begin
      chk_cnt++;
      if (got_inf_q[6] !== 16'd800) $display("FAIL hstep_inf_row2: got %0d, expected 800", got_inf_q[6]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_bubbles();
    res_t nb_q[$];
    res_t a, b;
    clear_queues();
    set_threshold(int'($urandom_range(1200)));
    fill_random();
    send_frame(W * H, 0);
    idle(6);
    nb_q = got_q;
    chk_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL rand_nb_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[i] !== exp_q[i]) report_res("rand_nb_res", i);
      else pass_cnt++;
    end
    clear_queues();
    send_frame(W * H, 30);
    idle(6);
    chk_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL rand_bub_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[i] !== exp_q[i]) report_res("rand_bub_res", i);
      else pass_cnt++;
    end
    for (int i = 0; i < got_q.size() && i < nb_q.size(); i++) begin
      a = got_q[i]; b = nb_q[i];
      a.stamp = '0; b.stamp = '0;
      chk_cnt++;
      if (a !== b) $display("FAIL rand_vs_nobubble[%0d]: got ix=%0d mag=%0d, expected ix=%0d mag=%0d", i, a.ix, a.mag, b.ix, b.mag);
      else pass_cnt++;
    end
    for (int i = 0; i < got_inf_q.size() && i < exp_inf_q.size(); i++) begin
      chk_cnt++;
      if (got_inf_q[i] !== exp_inf_q[i]) $display("FAIL rand_inf_mag[%0d]: got %0d, expected %0d", i, got_inf_q[i], exp_inf_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_midframe_reset();
    clear_queues();
    set_threshold(int'($urandom_range(1200)));
    fill_random();
    send_frame(20, 0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if ({out_valid, out_ix, out_iy, out_mag, out_edge, out_eol, inf_valid} !== 37'd0)
      $display("FAIL midreset_outputs: got valid=%b ix=%0d iy=%0d mag=%0d edge=%b eol=%b, expected all 0",
               out_valid, out_ix, out_iy, out_mag, out_edge, out_eol);
    else pass_cnt++;
    reset_n = 1'b1;
    clear_queues();
    idle(5);
    chk_cnt++;
    if (got_q.size() != 0) $display("FAIL midreset_spurious: got %0d results, expected 0", got_q.size());
    else pass_cnt++;
    fill_random();
    send_frame(W * H, 30);
    idle(6);
    chk_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL midreset_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[i] !== exp_q[i]) report_res("midreset_res", i);
      else pass_cnt++;
    end
  endtask

  task automatic test_midframe_sof();
    clear_queues();
    set_threshold(int'($urandom_range(1200)));
    fill_random();
    send_frame(3 * W + 5, 0);   // stops before (3,5); next pixel carries sof
    fill_random();
    send_frame(W * H, 0);
    fill_random();
    send_frame(W * H, 20);
    idle(6);
    chk_cnt++;
    if (got_q.size() != 57) $display("FAIL midsof_count: got %0d results, expected 57", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[i] !== exp_q[i]) report_res("midsof_res", i);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; threshold = '0;
    test_reset();
    test_constant();
    test_vertical_step();
    test_horizontal_step();
    test_random_bubbles();
    test_midframe_reset();
    test_midframe_sof();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
